// File: rtl/id_pkg.sv
// Shared decode-stage definitions: opcodes, EXE command encodings and
// the issue-history scoreboard entry.
package id_pkg;

    localparam int unsigned RegAddrW = 5;

    localparam logic [5:0] OpAdd  = 6'd1;
    localparam logic [5:0] OpSub  = 6'd3;
    localparam logic [5:0] OpAnd  = 6'd5;
    localparam logic [5:0] OpOr   = 6'd6;
    localparam logic [5:0] OpNor  = 6'd7;
    localparam logic [5:0] OpXor  = 6'd8;
    localparam logic [5:0] OpSla  = 6'd9;
    localparam logic [5:0] OpSll  = 6'd10;
    localparam logic [5:0] OpSra  = 6'd11;
    localparam logic [5:0] OpSrl  = 6'd12;
    localparam logic [5:0] OpAddi = 6'd32;
    localparam logic [5:0] OpSubi = 6'd33;
    localparam logic [5:0] OpLd   = 6'd36;
    localparam logic [5:0] OpSt   = 6'd37;
    localparam logic [5:0] OpBez  = 6'd40;
    localparam logic [5:0] OpBne  = 6'd41;
    localparam logic [5:0] OpJmp  = 6'd42;

    typedef enum logic [3:0] {
        ExeAdd = 4'b0000,
        ExeSub = 4'b0010,
        ExeAnd = 4'b0100,
        ExeOr  = 4'b0101,
        ExeNor = 4'b0110,
        ExeXor = 4'b0111,
        ExeShl = 4'b1000,
        ExeSra = 4'b1001,
        ExeSrl = 4'b1010
    } exe_cmd_e;

    typedef enum logic [2:0] {
        ClsNone, ClsRtype, ClsImm, ClsLoad, ClsStore, ClsBez, ClsBne, ClsJmp
    } instr_cls_e;

    typedef struct packed {
        logic                wb_en;
        logic                mem_r_en;
        logic [RegAddrW-1:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: IF/ID inputs, register-file read port, branch/stall
// feedback to IF and the registered ID/EX fields.
interface id_stage_pipe_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  instr_valid;
    logic [31:0]           instruction;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic                  stall;
    logic                  if_flush;
    logic                  br_taken;
    logic [DATA_W-1:0]     br_offset;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     val1;
    logic [DATA_W-1:0]     val2;
    logic [DATA_W-1:0]     reg2_out;
    logic [3:0]            exe_cmd;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  wb_en;

    modport master (
        output instr_valid, instruction, reg1, reg2,
        input  src1, src2, stall, if_flush, br_taken, br_offset,
        input  ex_valid, dest, val1, val2, reg2_out, exe_cmd, mem_r_en, mem_w_en, wb_en
    );

    modport slave (
        input  instr_valid, instruction, reg1, reg2,
        output src1, src2, stall, if_flush, br_taken, br_offset,
        output ex_valid, dest, val1, val2, reg2_out, exe_cmd, mem_r_en, mem_w_en, wb_en
    );
endinterface

// File: rtl/id_hazard_sb.sv
// Issue-history scoreboard and RAW hazard compare. Entry 0 is the
// instruction currently in EX; older entries follow.
module id_hazard_sb
    import id_pkg::*;
#(
    parameter int unsigned HAZ_DEPTH = 2,
    parameter bit          FWD_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze_i,
    input  sb_entry_t           issue_i,
    input  logic [RegAddrW-1:0] src1_i,
    input  logic [RegAddrW-1:0] src2_i,
    input  logic                used1_i,
    input  logic                used2_i,
    output logic                hazard_o
);
    sb_entry_t [HAZ_DEPTH-1:0] sb_q;
    sb_entry_t [HAZ_DEPTH-1:0] sb_d;

    function automatic logic src_hit(logic [RegAddrW-1:0] dest, logic [RegAddrW-1:0] s1,
                                     logic [RegAddrW-1:0] s2, logic u1, logic u2);
        return (u1 && s1 != '0 && s1 == dest) || (u2 && s2 != '0 && s2 == dest);
    endfunction

    always_comb begin
        sb_d = sb_q;
        if (!freeze_i) begin
            sb_d[0] = issue_i;
            for (int i = 1; i < int'(HAZ_DEPTH); i++) begin
                sb_d[i] = sb_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // With forwarding only a load in EX cannot supply its result in time.
    always_comb begin
        hazard_o = 1'b0;
        if (FWD_EN) begin
            hazard_o = sb_q[0].mem_r_en && src_hit(sb_q[0].dest, src1_i, src2_i, used1_i, used2_i);
        end else begin
            for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
                if (sb_q[i].wb_en && src_hit(sb_q[i].dest, src1_i, src2_i, used1_i, used2_i)) begin
                    hazard_o = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with branch resolution, RAW interlock and the ID/EX
// pipeline register.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned HAZ_DEPTH  = 2,
    parameter bit          FWD_EN     = 1'b1
) (
    input logic            clk,
    input logic            rst,
    input logic            freeze,
    id_stage_pipe_if.slave bus
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     val1;
        logic [DATA_W-1:0]     val2;
        logic [DATA_W-1:0]     reg2_out;
        exe_cmd_e              exe_cmd;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  wb_en;
    } idex_t;

    logic [5:0]          opcode;
    logic [RegAddrW-1:0] f_dest;
    logic [RegAddrW-1:0] f_src1;
    logic [RegAddrW-1:0] f_src2;
    logic [RegAddrW-1:0] src2_sel;
    logic [DATA_W-1:0]   imm_ext;
    instr_cls_e          cls_raw;
    instr_cls_e          cls;
    exe_cmd_e            cmd;
    logic                used1;
    logic                used2;
    logic                hazard;
    logic                br_cond;
    logic                br_taken;
    sb_entry_t           issue;
    idex_t               ex_d;
    idex_t               ex_q;

    assign opcode  = bus.instruction[31:26];
    assign f_dest  = bus.instruction[25:21];
    assign f_src1  = bus.instruction[20:16];
    assign f_src2  = bus.instruction[15:11];
    assign imm_ext = {{(DATA_W-16){bus.instruction[15]}}, bus.instruction[15:0]};

    always_comb begin
        cls_raw = ClsNone;
        cmd     = ExeAdd;
        case (opcode)
            OpAdd:  begin cls_raw = ClsRtype; cmd = ExeAdd; end
            OpSub:  begin cls_raw = ClsRtype; cmd = ExeSub; end
            OpAnd:  begin cls_raw = ClsRtype; cmd = ExeAnd; end
            OpOr:   begin cls_raw = ClsRtype; cmd = ExeOr;  end
            OpNor:  begin cls_raw = ClsRtype; cmd = ExeNor; end
            OpXor:  begin cls_raw = ClsRtype; cmd = ExeXor; end
            OpSla:  begin cls_raw = ClsRtype; cmd = ExeShl; end
            OpSll:  begin cls_raw = ClsRtype; cmd = ExeShl; end
            OpSra:  begin cls_raw = ClsRtype; cmd = ExeSra; end
            OpSrl:  begin cls_raw = ClsRtype; cmd = ExeSrl; end
            OpAddi: begin cls_raw = ClsImm;   cmd = ExeAdd; end
            OpSubi: begin cls_raw = ClsImm;   cmd = ExeSub; end
            OpLd:   cls_raw = ClsLoad;
            OpSt:   cls_raw = ClsStore;
            OpBez:  cls_raw = ClsBez;
            OpBne:  cls_raw = ClsBne;
            OpJmp:  cls_raw = ClsJmp;
            default: cls_raw = ClsNone;
        endcase
    end

    assign cls      = bus.instr_valid ? cls_raw : ClsNone;
    // ST/BEZ/BNE carry their second operand in the dest field.
    assign src2_sel = (cls_raw == ClsStore || cls_raw == ClsBez || cls_raw == ClsBne) ?
                      f_dest : f_src2;
    assign used1    = cls inside {ClsRtype, ClsImm, ClsLoad, ClsStore, ClsBez, ClsBne};
    assign used2    = cls inside {ClsRtype, ClsStore, ClsBne};

    always_comb begin
        br_cond = 1'b0;
        case (cls)
            ClsBez:  br_cond = (bus.reg1 == '0);
            ClsBne:  br_cond = (bus.reg1 != bus.reg2);
            ClsJmp:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken      = br_cond & ~freeze & ~hazard;
    assign bus.br_taken  = br_taken;
    assign bus.if_flush  = br_taken;
    assign bus.br_offset = imm_ext;
    assign bus.stall     = freeze | hazard;
    assign bus.src1      = REG_ADDR_W'(f_src1);
    assign bus.src2      = REG_ADDR_W'(src2_sel);

    always_comb begin
        ex_d = '0;
        if (freeze) begin
            ex_d = ex_q;
        end else if (!hazard && cls != ClsNone) begin
            ex_d.valid   = 1'b1;
            ex_d.exe_cmd = cmd;
            ex_d.val1    = bus.reg1;
            ex_d.val2    = imm_ext;
            unique case (cls)
                ClsRtype: begin
                    ex_d.dest  = REG_ADDR_W'(f_dest);
                    ex_d.val2  = bus.reg2;
                    ex_d.wb_en = 1'b1;
                end
                ClsImm: begin
                    ex_d.dest  = REG_ADDR_W'(f_dest);
                    ex_d.wb_en = 1'b1;
                end
                ClsLoad: begin
                    ex_d.dest     = REG_ADDR_W'(f_dest);
                    ex_d.wb_en    = 1'b1;
                    ex_d.mem_r_en = 1'b1;
                end
                ClsStore: begin
                    ex_d.reg2_out = bus.reg2;
                    ex_d.mem_w_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign issue = '{wb_en: ex_d.wb_en, mem_r_en: ex_d.mem_r_en, dest: f_dest};

    id_hazard_sb #(
        .HAZ_DEPTH (HAZ_DEPTH),
        .FWD_EN    (FWD_EN)
    ) u_hazard_sb (
        .clk      (clk),
        .rst      (rst),
        .freeze_i (freeze),
        .issue_i  (issue),
        .src1_i   (f_src1),
        .src2_i   (src2_sel),
        .used1_i  (used1),
        .used2_i  (used2),
        .hazard_o (hazard)
    );

    assign bus.ex_valid = ex_q.valid;
    assign bus.dest     = ex_q.dest;
    assign bus.val1     = ex_q.val1;
    assign bus.val2     = ex_q.val2;
    assign bus.reg2_out = ex_q.reg2_out;
    assign bus.exe_cmd  = ex_q.exe_cmd;
    assign bus.mem_r_en = ex_q.mem_r_en;
    assign bus.mem_w_en = ex_q.mem_w_en;
    assign bus.wb_en    = ex_q.wb_en;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench: one forwarding and one forwarding-less decode stage
// driven with identical stimulus, each checked where its behaviour matters.
module tb_id_stage_pipe;
    import id_pkg::*;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] reg1;
    logic [31:0] reg2;
    int          checks;
    int          errors;

    id_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) bus_f ();
    id_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) bus_n ();

    assign bus_f.instr_valid = instr_valid;
    assign bus_f.instruction = instruction;
    assign bus_f.reg1        = reg1;
    assign bus_f.reg2        = reg2;
    assign bus_n.instr_valid = instr_valid;
    assign bus_n.instruction = instruction;
    assign bus_n.reg1        = reg1;
    assign bus_n.reg2        = reg2;

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .HAZ_DEPTH(2), .FWD_EN(1'b1)) dut_f (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .bus    (bus_f)
    );

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .HAZ_DEPTH(2), .FWD_EN(1'b0)) dut_n (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .bus    (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins_r(logic [5:0] op, int d, int s1, int s2);
        return {op, 5'(d), 5'(s1), 5'(s2), 11'b0};
    endfunction

    function automatic logic [31:0] ins_i(logic [5:0] op, int d, int s1, logic [15:0] imm);
        return {op, 5'(d), 5'(s1), imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2);
        instr_valid = v;
        instruction = ins;
        reg1        = r1;
        reg2        = r2;
        #1;
    endtask

    task automatic drain();
        instr_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        freeze      = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        reg1        = '0;
        reg2        = '0;
        #1 rst = 1'b0;
        #1;
        chk("reset_ex_valid", 32'(bus_f.ex_valid), 32'd0);
        chk("reset_wb_en", 32'(bus_f.wb_en), 32'd0);
        chk("reset_val1", bus_f.val1, 32'd0);
        chk("reset_stall", 32'(bus_n.stall), 32'd0);
        tick();
        rst = 1'b1;
        drain();

        // ADD R3,R1,R2
        drive(1'b1, ins_r(OpAdd, 3, 1, 2), 32'd5, 32'd7);
        chk("add_stall", 32'(bus_f.stall), 32'd0);
        chk("add_src1", 32'(bus_f.src1), 32'd1);
        chk("add_src2", 32'(bus_f.src2), 32'd2);
        tick();
        chk("add_ex_valid", 32'(bus_f.ex_valid), 32'd1);
        chk("add_dest", 32'(bus_f.dest), 32'd3);
        chk("add_val1", bus_f.val1, 32'd5);
        chk("add_val2", bus_f.val2, 32'd7);
        chk("add_cmd", 32'(bus_f.exe_cmd), 32'b0000);
        chk("add_wb_en", 32'(bus_f.wb_en), 32'd1);
        drain();

        // Invalid instruction and unknown opcode both issue bubbles
        drive(1'b0, ins_r(OpAdd, 3, 1, 2), 32'd5, 32'd7);
        tick();
        chk("invalid_bubble", 32'(bus_f.ex_valid), 32'd0);
        drive(1'b1, 32'hFC00_0000, 32'd5, 32'd7);
        tick();
        chk("unknown_bubble", 32'(bus_f.ex_valid), 32'd0);
        chk("unknown_wb_en", 32'(bus_f.wb_en), 32'd0);
        drain();

        // Load-use with forwarding: LD R4 then ADD R5,R4,R1
        drive(1'b1, ins_i(OpLd, 4, 1, 16'd8), 32'd5, 32'd0);
        tick();
        chk("ld_mem_r_en", 32'(bus_f.mem_r_en), 32'd1);
        chk("ld_val2", bus_f.val2, 32'd8);
        drive(1'b1, ins_r(OpAdd, 5, 4, 1), 32'd5, 32'd5);
        chk("lu_stall", 32'(bus_f.stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(bus_f.ex_valid), 32'd0);
        chk("lu_stall_clear", 32'(bus_f.stall), 32'd0);
        tick();
        chk("lu_add_valid", 32'(bus_f.ex_valid), 32'd1);
        chk("lu_add_dest", 32'(bus_f.dest), 32'd5);
        drain();

        // No forwarding: ADDI R2 then SUB R6,R2,R1 stalls twice
        drive(1'b1, ins_i(OpAddi, 2, 1, 16'd1), 32'd5, 32'd0);
        tick();
        drive(1'b1, ins_r(OpSub, 6, 2, 1), 32'd5, 32'd5);
        chk("nf_stall1", 32'(bus_n.stall), 32'd1);
        tick();
        chk("nf_bubble1", 32'(bus_n.ex_valid), 32'd0);
        chk("nf_stall2", 32'(bus_n.stall), 32'd1);
        tick();
        chk("nf_bubble2", 32'(bus_n.ex_valid), 32'd0);
        chk("nf_stall_clear", 32'(bus_n.stall), 32'd0);
        tick();
        chk("nf_sub_valid", 32'(bus_n.ex_valid), 32'd1);
        chk("nf_sub_dest", 32'(bus_n.dest), 32'd6);
        chk("nf_sub_cmd", 32'(bus_n.exe_cmd), 32'b0010);
        drain();

        // MEM-stage producer costs one stall
        drive(1'b1, ins_i(OpAddi, 2, 1, 16'd1), 32'd5, 32'd0);
        tick();
        drive(1'b1, ins_r(OpAdd, 7, 1, 1), 32'd5, 32'd5);
        tick();
        drive(1'b1, ins_r(OpSub, 6, 2, 1), 32'd5, 32'd5);
        chk("nf_mem_stall", 32'(bus_n.stall), 32'd1);
        tick();
        chk("nf_mem_stall_clear", 32'(bus_n.stall), 32'd0);
        drain();

        // R0 never hazards
        drive(1'b1, ins_i(OpAddi, 0, 1, 16'd1), 32'd5, 32'd0);
        tick();
        drive(1'b1, ins_r(OpSub, 6, 0, 1), 32'd0, 32'd5);
        chk("nf_r0_stall", 32'(bus_n.stall), 32'd0);
        tick();
        chk("nf_r0_valid", 32'(bus_n.ex_valid), 32'd1);
        drain();

        // BNE taken, then not taken
        drive(1'b1, ins_i(OpBne, 2, 1, 16'hFFFC), 32'd1, 32'd2);
        chk("bne_taken", 32'(bus_f.br_taken), 32'd1);
        chk("bne_flush", 32'(bus_f.if_flush), 32'd1);
        chk("bne_offset", bus_f.br_offset, 32'hFFFF_FFFC);
        chk("bne_src2", 32'(bus_f.src2), 32'd2);
        tick();
        chk("bne_ex_valid", 32'(bus_f.ex_valid), 32'd1);
        chk("bne_wb_en", 32'(bus_f.wb_en), 32'd0);
        chk("bne_mem_w_en", 32'(bus_f.mem_w_en), 32'd0);
        drive(1'b1, ins_i(OpBne, 2, 1, 16'hFFFC), 32'd1, 32'd1);
        chk("bne_not_taken", 32'(bus_f.br_taken), 32'd0);
        drain();

        // ST R2 -> mem[R1+4]
        drive(1'b1, ins_i(OpSt, 2, 1, 16'd4), 32'd100, 32'd55);
        tick();
        chk("st_mem_w_en", 32'(bus_f.mem_w_en), 32'd1);
        chk("st_reg2_out", bus_f.reg2_out, 32'd55);
        chk("st_wb_en", 32'(bus_f.wb_en), 32'd0);
        drain();

        // Freeze during load-use stall
        drive(1'b1, ins_i(OpLd, 4, 1, 16'd8), 32'd5, 32'd0);
        tick();
        drive(1'b1, ins_r(OpAdd, 5, 4, 1), 32'd5, 32'd5);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_ex_valid", 32'(bus_f.ex_valid), 32'd1);
            chk("frz_mem_r_en", 32'(bus_f.mem_r_en), 32'd1);
            chk("frz_dest", 32'(bus_f.dest), 32'd4);
            chk("frz_stall", 32'(bus_f.stall), 32'd1);
        end
        drive(1'b1, ins_i(OpJmp, 0, 0, 16'd12), 32'd5, 32'd5);
        chk("frz_jmp_br", 32'(bus_f.br_taken), 32'd0);
        drive(1'b1, ins_r(OpAdd, 5, 4, 1), 32'd5, 32'd5);
        freeze = 1'b0;
        #1;
        chk("frz_post_stall", 32'(bus_f.stall), 32'd1);
        tick();
        chk("frz_post_bubble", 32'(bus_f.ex_valid), 32'd0);
        chk("frz_post_clear", 32'(bus_f.stall), 32'd0);
        tick();
        chk("frz_post_dest", 32'(bus_f.dest), 32'd5);
        drain();

        // Hazard and branch together: stall wins, branch resolves after
        drive(1'b1, ins_i(OpLd, 4, 1, 16'd8), 32'd5, 32'd0);
        tick();
        drive(1'b1, ins_i(OpBez, 0, 4, 16'h0010), 32'd0, 32'd0);
        chk("hb_stall", 32'(bus_f.stall), 32'd1);
        chk("hb_br_held", 32'(bus_f.br_taken), 32'd0);
        tick();
        chk("hb_br_taken", 32'(bus_f.br_taken), 32'd1);
        chk("hb_offset", bus_f.br_offset, 32'h0000_0010);
        drain();

        // Reset asserted mid-stall, ADD in ID issues after release
        drive(1'b1, ins_i(OpLd, 4, 1, 16'd8), 32'd5, 32'd0);
        tick();
        drive(1'b1, ins_r(OpAdd, 5, 4, 1), 32'd5, 32'd5);
        chk("rs_stall_before", 32'(bus_f.stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("rs_ex_valid", 32'(bus_f.ex_valid), 32'd0);
        chk("rs_mem_r_en", 32'(bus_f.mem_r_en), 32'd0);
        chk("rs_stall_cleared", 32'(bus_f.stall), 32'd0);
        tick();
        chk("rs_held_in_reset", 32'(bus_f.ex_valid), 32'd0);
        rst = 1'b1;
        tick();
        chk("rs_issue_valid", 32'(bus_f.ex_valid), 32'd1);
        chk("rs_issue_dest", 32'(bus_f.dest), 32'd5);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage with an integrated ID/EX pipeline register, RAW-hazard interlock and branch resolution for the 5-stage core. It sits between the IF/ID register and EXE. It decodes the instruction and drives register-file read addresses. It resolves branches in ID with a same-cycle IF flush, and stalls IF on data hazards, using an internal issue-history scoreboard. Forwarding-aware or forwarding-less interlocking is selected by parameter.

## Interface
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero and never hazards
- HAZ_DEPTH, 2, issue-history depth (EX, MEM, …) checked for hazards when FWD_EN=0
- FWD_EN, 1, 1: stall only on load-use; 0: stall on any in-flight write to a source

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  memory freeze: hold all state
- instr_valid  in  1  IF/ID holds a valid instruction
- instruction  in  32  from IF/ID
- src1, src2  out  REG_ADDR_W  register-file read addresses (combinational)
- reg1, reg2  in  DATA_W  register-file read data (combinational)
- stall  out  1  hold PC and IF/ID (combinational)
- if_flush, br_taken  out  1  branch taken this cycle (combinational)
- br_offset  out  DATA_W  sign-extended imm[15:0] (combinational)
- ex_valid, dest, val1, val2, reg2_out, exe_cmd(4), mem_r_en, mem_w_en, wb_en  out  registered ID/EX fields

## Operation
- Fields: opcode [31:26], dest [25:21], src1 = [20:16] always; src2 = [15:11] for R-type, [25:21] for ST/BEZ/BNE.
- R-type (ADD, SUB, AND, OR, NOR, XOR, SLA, SLL, SRA, SRL):
  - val1 = reg1, val2 = reg2, wb_en = 1.
- ADDI/SUBI/LD:
  - val2 = sext(imm); wb_en = 1.
  - LD additionally sets mem_r_en = 1.
- ST:
  - val2 = sext(imm), reg2_out = reg2, mem_w_en = 1, wb_en = 0.
- Branches:
  - BEZ is taken if reg1 == 0; BNE if reg1 != reg2; JMP always.
  - A branch issues to EX with all enables 0 and ex_valid = 1.
- Unknown opcode or instr_valid = 0: issue a bubble (ex_valid and all enables 0).
- Scoreboard: HAZ_DEPTH entries {wb_en, mem_r_en, dest}. Entry 0 mirrors the ID/EX register; the history shifts each non-frozen cycle.
- Hazard is evaluated only for sources the opcode actually reads:
  - FWD_EN = 1: hazard if entry 0 has mem_r_en = 1 and its dest equals a used source.
  - FWD_EN = 0: hazard if any entry with wb_en = 1 has a dest equal to a used source.
  - Sources or dests equal to 0 never match.
- On hazard: stall = 1, a bubble is issued, and br_taken/if_flush are forced to 0 (a branch waits for its operands).
- freeze = 1:
  - All registers hold, including the scoreboard.
  - stall = 1; br_taken = if_flush = 0.
  - freeze takes priority over hazard and branch.

## Timing
- Reset (rst = 0, asynchronous): every registered output is 0 and all scoreboard entries are invalid. Combinational outputs follow their inputs.
- Decode-to-EX latency is 1 cycle: the ID/EX register loads on the rising edge when freeze = 0.
- The branch decision is visible in the same cycle as the instruction in ID. IF discards the next fetch when if_flush = 1.
- Load-use with FWD_EN = 1 costs exactly 1 stall cycle.
- RAW against the EX-stage producer with FWD_EN = 0 and HAZ_DEPTH = 2 costs 2 stall cycles; against the MEM-stage producer it costs 1.
- Reset asserted mid-stall: the stall clears once the scoreboard empties, and the instruction in ID issues on the first edge after rst rises.
- Simultaneous hazard and branch: the stall wins and the branch resolves on the post-stall cycle.

## Structure
- The shared package id_pkg holds opcode constants, EXE_CMD encodings (ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLA/SLL 1000, SRA 1001, SRL 1010) and the scoreboard entry typedef.
- One sub-module, id_hazard_sb, contains the scoreboard shift register and the hazard compare. The parent holds decode, branch logic and the ID/EX register.

## Test plan
- rst pulsed low mid-run with a valid ADD in ID → all registered outputs are 0 within the reset cycle; ex_valid = 0 on the first edge after release unless freeze = 0 and the instruction is valid.
- ADD R3,R1,R2 with reg1 = 5, reg2 = 7 → next cycle: ex_valid = 1, dest = 3, val1 = 5, val2 = 7, exe_cmd = 0000, wb_en = 1, stall = 0.
- FWD_EN = 1: LD R4 followed by ADD R5,R4,R1 → stall = 1 for one cycle and a bubble in EX; then ADD issues with dest = 5.
- FWD_EN = 0, HAZ_DEPTH = 2: ADDI R2 followed by SUB R6,R2,R1 → stall for 2 cycles, 2 bubbles, then SUB issues. The same sequence with src = R0 gives no stall.
- BNE with reg1 = 1, reg2 = 2, imm = 0xFFFC → br_taken = if_flush = 1 and br_offset = 0xFFFFFFFC in the same cycle; the next cycle has wb_en = mem_w_en = 0.
- freeze = 1 for 3 cycles during a load-use stall → ID/EX and the scoreboard hold and br_taken = 0. After release, the remaining stall completes normally.
